// File: rtl/stall_sequencer.sv
// rtl/stall_sequencer.sv - global pipeline stall controller with staged downstream-first release
// Registered all-stage stall, watermark hysteresis, stall-cycle counter and stall watchdog.
module stall_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 4,
  parameter int HI_WM      = 12,
  parameter int LO_WM      = 4,
  parameter int MIN_STALL  = 2,
  parameter int MAX_STALL  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_STAGES-1:0] stage_full,
  input  logic [CNT_W-1:0]      buf_count,
  input  logic                  clr_err,
  output logic [NUM_STAGES-1:0] stall_vec,
  output logic                  stall_any,
  output logic [1:0]            state,
  output logic [15:0]           stall_cycles,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    RESUME = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HI_TH  = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] LO_TH  = CNT_W'(LO_WM);
  localparam logic [15:0]      MIN_TH = 16'(MIN_STALL - 1);
  localparam logic [15:0]      MAX_TH = 16'(MAX_STALL);

  state_t                cur;
  logic [15:0]           stall_cnt;
  logic                  wd_done;
  logic                  press;
  logic                  calm;
  logic                  wd_fire;
  logic [NUM_STAGES-1:0] release_vec;
  logic                  found;

  assign press     = (|stage_full) || (buf_count >= HI_TH);
  assign calm      = (~|stage_full) && (buf_count <= LO_TH);
  assign stall_any = |stall_vec;
  assign state     = cur;

  // Watchdog fires once per STALL episode, so clr_err can clear it while the counter sits saturated.
  assign wd_fire = (cur == STALL) && (stall_cnt == MAX_TH) && !wd_done;

  always_comb begin
    release_vec = stall_vec;
    found       = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!found && stall_vec[i]) begin
        release_vec[i] = 1'b0;
        found          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur          <= RUN;
      stall_vec    <= '0;
      stall_cnt    <= '0;
      wd_done      <= 1'b0;
      stall_cycles <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (stall_any && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;

      if (wd_fire)
        timeout_err <= 1'b1;
      else if (clr_err)
        timeout_err <= 1'b0;

      if (!enable) begin
        cur       <= RUN;
        stall_vec <= '0;
        stall_cnt <= '0;
        wd_done   <= 1'b0;
      end else begin
        case (cur)
          RUN: begin
            stall_cnt <= '0;
            if (press) begin
              cur       <= STALL;
              stall_vec <= '1;
              wd_done   <= 1'b0;
            end
          end
          STALL: begin
            if ((stall_cnt >= MIN_TH) && calm) begin
              cur       <= RESUME;
              stall_vec <= release_vec;
              stall_cnt <= '0;
              wd_done   <= 1'b0;
            end else begin
              if (stall_cnt != MAX_TH)
                stall_cnt <= stall_cnt + 16'd1;
              if (wd_fire)
                wd_done <= 1'b1;
            end
          end
          RESUME: begin
            if (press) begin
              cur       <= STALL;
              stall_vec <= '1;
              stall_cnt <= '0;
              wd_done   <= 1'b0;
            end else begin
              stall_vec <= release_vec;
              if (release_vec == '0)
                cur <= RUN;
            end
          end
          default: begin
            cur       <= RUN;
            stall_vec <= '0;
            stall_cnt <= '0;
            wd_done   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stall_sequencer.sv
// tb/tb_stall_sequencer.sv - scoreboard bench for stall_sequencer
module tb_stall_sequencer;

  localparam int N    = 4;
  localparam int HI   = 12;
  localparam int LO   = 4;
  localparam int MINS = 2;
  localparam int MAXS = 255;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  stage_full;
  logic [3:0]  buf_count;
  logic        clr_err;
  logic [3:0]  stall_vec;
  logic        stall_any;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        timeout_err;

  stall_sequencer #(
    .NUM_STAGES(N), .CNT_W(4), .HI_WM(HI), .LO_WM(LO), .MIN_STALL(MINS), .MAX_STALL(MAXS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .stage_full(stage_full),
    .buf_count(buf_count), .clr_err(clr_err), .stall_vec(stall_vec),
    .stall_any(stall_any), .state(state), .stall_cycles(stall_cycles),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vec;
    logic [1:0]  st;
    logic [15:0] cyc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;

  // Reference model: stall depth tracked as a level count rather than a bit vector.
  int ms, mlvl, mcnt, mdone, merr, mcyc;

  task automatic model_reset();
    ms = 0; mlvl = 0; mcnt = 0; mdone = 0; merr = 0; mcyc = 0;
  endtask

  task automatic drive(input logic [3:0] sf, input logic [3:0] bc, input logic en, input logic clr);
    bit press, calm, set;
    exp_t x;
    stage_full = sf; buf_count = bc; enable = en; clr_err = clr;
    press = (sf != 0) || (int'(bc) >= HI);
    calm  = (sf == 0) && (int'(bc) <= LO);
    set   = (ms == 1) && (mcnt == MAXS) && (mdone == 0);
    if (mlvl > 0 && mcyc < 65535) mcyc++;
    if (set) merr = 1; else if (clr) merr = 0;
    if (!en) begin
      ms = 0; mlvl = 0; mcnt = 0; mdone = 0;
    end else if (ms == 0) begin
      if (press) begin ms = 1; mlvl = N; mcnt = 0; mdone = 0; end
    end else if (ms == 1) begin
      if (mcnt >= MINS - 1 && calm) begin
        ms = 2; mlvl = N - 1; mcnt = 0; mdone = 0;
      end else begin
        if (mcnt < MAXS) mcnt++;
        if (set) mdone = 1;
      end
    end else begin
      if (press) begin ms = 1; mlvl = N; mcnt = 0; mdone = 0; end
      else begin mlvl--; if (mlvl == 0) ms = 0; end
    end
    x.vec = 4'((1 << mlvl) - 1);
    x.st  = 2'(ms);
    x.cyc = 16'(mcyc);
    x.err = merr[0];
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; stage_full = '0; buf_count = '0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall_vec !== 4'b0000 || state !== 2'b00 || stall_cycles !== 16'd0 ||
        timeout_err !== 1'b0 || stall_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: vec=%b st=%0d cyc=%0d err=%b any=%b want all zero",
               stall_vec, state, stall_cycles, timeout_err, stall_any);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 4'd0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL idle_run[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [3:0] tbl [6];
    tbl = '{4'b1111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      drive(i == 0 ? 4'b0010 : 4'b0000, 4'd0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL pulse_model[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
      checks++;
      if (stall_vec !== tbl[i]) begin
        errors++;
        $display("FAIL pulse_seq[%0d]: vec=%b want %b", i, stall_vec, tbl[i]);
      end
    end
    checks++;
    if (stall_cycles !== 16'd5 || state !== 2'b00) begin
      errors++;
      $display("FAIL pulse_count: stall_cycles=%0d st=%0d want 5 and RUN", stall_cycles, state);
    end
  endtask

  task automatic test_watermark();
    for (int i = 0; i <= 24; i++) begin
      logic [3:0] bc;
      bc = (i <= 12) ? 4'(i) : 4'(24 - i);
      drive(4'b0000, bc, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL wm_model[bc=%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 bc, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
      if (i > 12 && bc >= 4'd4) begin
        checks++;
        if (state !== ((bc == 4'd4) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL wm_hyst[bc=%0d]: st=%0d want %0d", bc, state, (bc == 4'd4) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_resume_restall();
    logic [3:0] sf;
    for (int i = 0; i < 10; i++) begin
      sf = (i == 0) ? 4'b0010 : (i == 4) ? 4'b1000 : 4'b0000;
      drive(sf, 4'd0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL restall_model[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
      if (i == 3 || i == 4 || i == 5) begin
        checks++;
        if ({stall_vec, state} !== ((i == 3) ? 6'b0011_10 : 6'b1111_01)) begin
          errors++;
          $display("FAIL restall_seq[%0d]: vec=%b st=%0d", i, stall_vec, state);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    int first_err;
    logic clr;
    first_err = -1;
    for (int i = 0; i < 300; i++) begin
      clr = (ms == 1 && mcnt == MAXS && mdone == 0);
      drive(4'b0001, 4'd0, 1'b1, clr);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL wd_model[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
      if (timeout_err === 1'b1 && first_err < 0) first_err = i;
    end
    checks++;
    if (first_err != 256 || stall_vec !== 4'b1111) begin
      errors++;
      $display("FAIL wd_rise: first err at sample %0d vec=%b want 256 and 1111", first_err, stall_vec);
    end
    for (int i = 0; i < 7; i++) begin
      drive(i < 2 ? 4'b0001 : 4'b0000, 4'd0, 1'b1, i == 0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL wd_clear[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 7; i++) begin
      drive(i < 5 ? 4'b0100 : 4'b0000, 4'd0, !(i == 2 || i == 3), 1'b0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL enable_model[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (stall_vec !== ((i == 2 || i == 3) ? 4'b0000 : 4'b1111)) begin
          errors++;
          $display("FAIL enable_seq[%0d]: vec=%b", i, stall_vec);
        end
      end
    end
    repeat (4) begin
      drive(4'b0000, 4'd0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(i == 0 ? 4'b1000 : 4'b0000, 4'd0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (stall_vec !== 4'b0111 || state !== 2'b10) begin
      errors++;
      $display("FAIL areset_setup: vec=%b st=%0d want 0111 RESUME", stall_vec, state);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (stall_vec !== 4'b0000 || state !== 2'b00 || stall_cycles !== 16'd0 ||
        timeout_err !== 1'b0 || stall_any !== 1'b0) begin
      errors++;
      $display("FAIL areset_async: vec=%b st=%0d cyc=%0d err=%b want all zero",
               stall_vec, state, stall_cycles, timeout_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'd0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (stall_vec !== e.vec || state !== e.st || stall_cycles !== e.cyc ||
          timeout_err !== e.err || stall_any !== (e.vec != 0)) begin
        errors++;
        $display("FAIL areset_after[%0d]: vec=%b st=%0d cyc=%0d err=%b want vec=%b st=%0d cyc=%0d err=%b",
                 i, stall_vec, state, stall_cycles, timeout_err, e.vec, e.st, e.cyc, e.err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_watermark();
    test_resume_restall();
    test_watchdog();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
